// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one pipelined 32x32 multiplier among NREQ requesters.
// A tag pipe matched to the multiplier latency routes each product back to its issuer.
module mul_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic [63:0]        mul_p,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [63:0]        rsp_p,
  output logic               busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [31:0]              mul_a_q, mul_b_q;
  logic [LAT:0]             tag_vld_q;
  logic [LAT:0][IdxW-1:0]   tag_idx_q;

  logic                     grant_found;
  logic [IdxW-1:0]          grant_idx;
  logic [IdxW:0]            scan_sum;
  logic [IdxW-1:0]          scan_idx;
  logic                     xfer;

  // Scan ptr, ptr+1, ... modulo NREQ; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (scan_sum >= (IdxW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IdxW+1)'(NREQ);
      end
      scan_idx = scan_sum[IdxW-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign xfer = grant_found & ~reset;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (grant_idx == IdxW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= {tag_vld_q[LAT-1:0], xfer};
      tag_idx_q <= {tag_idx_q[LAT-1:0], grant_idx};
      if (xfer) begin
        mul_a_q <= req_a[32*grant_idx +: 32];
        mul_b_q <= req_b[32*grant_idx +: 32];
      end
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign rsp_p = mul_p;

  // Gated during reset so products of discarded operations never surface.
  always_comb begin
    rsp_valid = '0;
    if (tag_vld_q[LAT] && !reset) begin
      rsp_valid[tag_idx_q[LAT]] = 1'b1;
    end
  end

  assign busy = (|req_valid) | (|tag_vld_q);

endmodule
